// File: rtl/mem_arb_pkg.sv
// Shared types for the data_mem port arbiter: FSM state, read-owner encoding
// and the full-word byte mask used for instruction fetches.
package mem_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_WAIT_RD} arb_state_t;
   typedef enum logic {OWN_IF, OWN_LSU} arb_owner_t;

   localparam logic [3:0] MASK_FULL = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data_mem between instruction fetch and the LSU:
// one grant per cycle, reads block new grants until their response returns.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int LSU_PRIO   = 1,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              lsu_req,
   input  logic              lsu_we,
   input  logic [3:0]        lsu_mask,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   output logic              lsu_gnt,
   output logic              lsu_rvalid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_request,
   output logic              mem_we_re,
   output logic              mem_load,
   output logic [3:0]        mem_mask,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_data_out
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

   arb_state_t r_state, w_state_next;
   arb_owner_t r_owner, w_owner_next;
   arb_owner_t r_last_gnt, w_last_gnt_next;
   logic [3:0] r_starve_cnt, w_starve_cnt_next;

   logic w_gnt_if, w_gnt_lsu, w_tie, w_store, w_read, w_rd_done;

   // Grant decision; everything is held off while reset is asserted.
   always_comb begin
      w_gnt_if  = 1'b0;
      w_gnt_lsu = 1'b0;
      w_tie     = if_req & lsu_req;
      if (!rst && r_state == ARB_IDLE) begin
         if (r_starve_cnt == STARVE_MAX && if_req) begin
            w_gnt_if = 1'b1;
         end else if (w_tie) begin
            if (LSU_PRIO != 0 || r_last_gnt == OWN_IF) begin
               w_gnt_lsu = 1'b1;
            end else begin
               w_gnt_if = 1'b1;
            end
         end else begin
            w_gnt_if  = if_req;
            w_gnt_lsu = lsu_req;
         end
      end
   end

   assign w_store   = w_gnt_lsu & lsu_we;
   assign w_read    = w_gnt_if | (w_gnt_lsu & ~lsu_we);
   assign w_rd_done = ~rst & (r_state == ARB_WAIT_RD) & mem_valid;

   always_comb begin
      w_state_next      = r_state;
      w_owner_next      = r_owner;
      w_last_gnt_next   = r_last_gnt;
      w_starve_cnt_next = r_starve_cnt;
      if (w_gnt_if || w_gnt_lsu) begin
         w_last_gnt_next = w_gnt_lsu ? OWN_LSU : OWN_IF;
      end
      if (w_read) begin
         w_state_next = ARB_WAIT_RD;
         w_owner_next = w_gnt_lsu ? OWN_LSU : OWN_IF;
      end else if (w_rd_done) begin
         w_state_next = ARB_IDLE;
      end
      // Only tie-wins by the LSU count towards starving a waiting IF.
      if (!if_req || w_gnt_if) begin
         w_starve_cnt_next = 4'd0;
      end else if (w_gnt_lsu && w_tie && r_starve_cnt < STARVE_MAX) begin
         w_starve_cnt_next = r_starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ARB_IDLE;
         r_owner      <= OWN_IF;
         r_last_gnt   <= OWN_IF;
         r_starve_cnt <= 4'd0;
      end else begin
         r_state      <= w_state_next;
         r_owner      <= w_owner_next;
         r_last_gnt   <= w_last_gnt_next;
         r_starve_cnt <= w_starve_cnt_next;
      end
   end

   always_comb begin
      if_gnt      = w_gnt_if;
      lsu_gnt     = w_gnt_lsu;
      mem_request = w_gnt_if | w_gnt_lsu;
      mem_we_re   = w_store;
      mem_load    = w_read;
      mem_mask    = 4'd0;
      mem_address = '0;
      mem_data_in = '0;
      if (w_gnt_lsu) begin
         mem_mask    = lsu_we ? lsu_mask : MASK_FULL;
         mem_address = lsu_addr;
         mem_data_in = lsu_we ? lsu_wdata : '0;
      end else if (w_gnt_if) begin
         mem_mask    = MASK_FULL;
         mem_address = if_addr;
      end
      // Data buses follow memory directly; only the valid strobe is routed.
      if_rvalid  = w_rd_done & (r_owner == OWN_IF);
      lsu_rvalid = w_rd_done & (r_owner == OWN_LSU);
      if_rdata   = rst ? '0 : mem_data_out;
      lsu_rdata  = rst ? '0 : mem_data_out;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: instance a (LSU priority) and instance b (round-robin),
// each with its own one-cycle-latency memory model.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        rv;
      logic        who;
      logic        req;
      logic        we;
      logic        ld;
      logic [3:0]  mask;
      logic [7:0]  addr;
      logic [31:0] data;
   } ev_t;

   logic clk, rst, init_mem;
   int   total, bad;
   ev_t  qa[$], qb[$];

   logic        a_if_req, a_if_gnt, a_if_rvalid, a_lsu_req, a_lsu_we, a_lsu_gnt, a_lsu_rvalid;
   logic [7:0]  a_if_addr, a_lsu_addr, a_mem_address;
   logic [3:0]  a_lsu_mask, a_mem_mask;
   logic [31:0] a_lsu_wdata, a_if_rdata, a_lsu_rdata, a_mem_data_in, a_mdo;
   logic        a_mem_request, a_mem_we_re, a_mem_load, a_mv, a_extra_valid;

   logic        b_if_req, b_if_gnt, b_if_rvalid, b_lsu_req, b_lsu_we, b_lsu_gnt, b_lsu_rvalid;
   logic [7:0]  b_if_addr, b_lsu_addr, b_mem_address;
   logic [3:0]  b_lsu_mask, b_mem_mask;
   logic [31:0] b_lsu_wdata, b_if_rdata, b_lsu_rdata, b_mem_data_in, b_mdo;
   logic        b_mem_request, b_mem_we_re, b_mem_load, b_mv;

   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .LSU_PRIO(1), .STARVE_LIM(4)) dut_a (
      .clk(clk), .rst(rst),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
      .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
      .lsu_req(a_lsu_req), .lsu_we(a_lsu_we), .lsu_mask(a_lsu_mask),
      .lsu_addr(a_lsu_addr), .lsu_wdata(a_lsu_wdata), .lsu_gnt(a_lsu_gnt),
      .lsu_rvalid(a_lsu_rvalid), .lsu_rdata(a_lsu_rdata),
      .mem_request(a_mem_request), .mem_we_re(a_mem_we_re), .mem_load(a_mem_load),
      .mem_mask(a_mem_mask), .mem_address(a_mem_address), .mem_data_in(a_mem_data_in),
      .mem_valid(a_mv | a_extra_valid), .mem_data_out(a_mdo)
   );

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .LSU_PRIO(0), .STARVE_LIM(4)) dut_b (
      .clk(clk), .rst(rst),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
      .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .lsu_req(b_lsu_req), .lsu_we(b_lsu_we), .lsu_mask(b_lsu_mask),
      .lsu_addr(b_lsu_addr), .lsu_wdata(b_lsu_wdata), .lsu_gnt(b_lsu_gnt),
      .lsu_rvalid(b_lsu_rvalid), .lsu_rdata(b_lsu_rdata),
      .mem_request(b_mem_request), .mem_we_re(b_mem_we_re), .mem_load(b_mem_load),
      .mem_mask(b_mem_mask), .mem_address(b_mem_address), .mem_data_in(b_mem_data_in),
      .mem_valid(b_mv), .mem_data_out(b_mdo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no end want end");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] data_pat(input logic [7:0] addr);
      return {8'hA5, addr, ~addr, 8'h3C};
   endfunction

   // Memory models: registered read, masked byte writes.
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 256; i++) begin
            mem_a[i] <= data_pat(8'(i));
            mem_b[i] <= data_pat(8'(i));
         end
         mem_a[8'h10] <= 32'hDEADBEEF;
         mem_a[8'h20] <= 32'h12345678;
         a_mv <= 1'b0;
         b_mv <= 1'b0;
      end else begin
         a_mv <= a_mem_load;
         b_mv <= b_mem_load;
         if (a_mem_load) a_mdo <= mem_a[a_mem_address];
         if (b_mem_load) b_mdo <= mem_b[b_mem_address];
         for (int k = 0; k < 4; k++) begin
            if (a_mem_request && a_mem_we_re && a_mem_mask[k])
               mem_a[a_mem_address][8*k +: 8] <= a_mem_data_in[8*k +: 8];
            if (b_mem_request && b_mem_we_re && b_mem_mask[k])
               mem_b[b_mem_address][8*k +: 8] <= b_mem_data_in[8*k +: 8];
         end
      end
   end

   function automatic ev_t g_ev(input logic who, input logic we, input logic [3:0] mask,
                                input logic [7:0] addr, input logic [31:0] data);
      ev_t e;
      e.rv = 1'b0; e.who = who; e.req = 1'b1; e.we = we; e.ld = ~we;
      e.mask = (who && !we) ? 4'h0 : mask;
      e.addr = addr;
      e.data = we ? data : 32'h0;
      return e;
   endfunction

   function automatic ev_t r_ev(input logic who, input logic [31:0] data);
      ev_t e;
      e = '0;
      e.rv = 1'b1; e.who = who; e.data = data;
      return e;
   endfunction

   task automatic cmp_pop(input int inst, input ev_t obs);
      ev_t e;
      total++;
      if ((inst == 0 && qa.size() == 0) || (inst == 1 && qb.size() == 0)) begin
         bad++;
         $display("FAIL inst%0d unexpected_event: got %h want none", inst, obs);
      end else begin
         if (inst == 0) e = qa.pop_front();
         else           e = qb.pop_front();
         if (obs !== e) begin
            bad++;
            $display("FAIL inst%0d %s: got %h want %h", inst, e.rv ? "rvalid" : "grant", obs, e);
         end else begin
            $display("inst%0d %s who=%0d addr=%h data=%h ok", inst, e.rv ? "rvalid" : "grant",
                     e.who, e.addr, e.data);
         end
      end
   endtask

   task automatic mon(input int inst, input logic ig, input logic lg, input logic iv,
                      input logic lv, input logic req, input logic we, input logic ld,
                      input logic [3:0] mask, input logic [7:0] addr, input logic [31:0] din,
                      input logic [31:0] ird, input logic [31:0] lrd);
      ev_t obs;
      total++;
      if (ig && lg) begin
         bad++;
         $display("FAIL inst%0d onehot: got if_gnt=%b lsu_gnt=%b want at most one", inst, ig, lg);
      end
      if (ig || lg) begin
         obs.rv = 1'b0; obs.who = lg; obs.req = req; obs.we = we; obs.ld = ld;
         obs.mask = (lg && ld) ? 4'h0 : mask;
         obs.addr = addr;
         obs.data = we ? din : 32'h0;
         cmp_pop(inst, obs);
      end else begin
         total++;
         if ({req, we, ld, mask, addr, din} != '0) begin
            bad++;
            $display("FAIL inst%0d idle_bus: got req=%b we=%b ld=%b mask=%h addr=%h din=%h want 0",
                     inst, req, we, ld, mask, addr, din);
         end
      end
      if (iv || lv) begin
         obs = '0;
         obs.rv = 1'b1; obs.who = lv; obs.we = iv & lv;
         obs.data = lv ? lrd : ird;
         cmp_pop(inst, obs);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && !init_mem) begin
         mon(0, a_if_gnt, a_lsu_gnt, a_if_rvalid, a_lsu_rvalid, a_mem_request, a_mem_we_re,
             a_mem_load, a_mem_mask, a_mem_address, a_mem_data_in, a_if_rdata, a_lsu_rdata);
         mon(1, b_if_gnt, b_lsu_gnt, b_if_rvalid, b_lsu_rvalid, b_mem_request, b_mem_we_re,
             b_mem_load, b_mem_mask, b_mem_address, b_mem_data_in, b_if_rdata, b_lsu_rdata);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_zero();
      @(negedge clk);
      total++;
      if ({a_if_gnt, a_lsu_gnt, a_if_rvalid, a_lsu_rvalid, a_if_rdata, a_lsu_rdata, a_mem_request,
           a_mem_we_re, a_mem_load, a_mem_mask, a_mem_address, a_mem_data_in} != '0) begin
         bad++;
         $display("FAIL inst0 reset_outputs: got gnt=%b%b rv=%b%b rd=%h/%h req=%b want all 0",
                  a_if_gnt, a_lsu_gnt, a_if_rvalid, a_lsu_rvalid, a_if_rdata, a_lsu_rdata,
                  a_mem_request);
      end else $display("inst0 reset outputs zero ok");
      total++;
      if ({b_if_gnt, b_lsu_gnt, b_if_rvalid, b_lsu_rvalid, b_mem_request, b_mem_load} != '0) begin
         bad++;
         $display("FAIL inst1 reset_outputs: got gnt=%b%b rv=%b%b req=%b want all 0",
                  b_if_gnt, b_lsu_gnt, b_if_rvalid, b_lsu_rvalid, b_mem_request);
      end else $display("inst1 reset outputs zero ok");
   endtask

   task automatic a_store(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] mask);
      a_lsu_req = 1'b1; a_lsu_we = 1'b1; a_lsu_addr = addr; a_lsu_wdata = data; a_lsu_mask = mask;
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; init_mem = 1'b1; a_extra_valid = 1'b0;
      a_if_req = 0; a_if_addr = 0; a_lsu_req = 0; a_lsu_we = 0; a_lsu_mask = 0;
      a_lsu_addr = 0; a_lsu_wdata = 0; a_mdo = 0;
      b_if_req = 0; b_if_addr = 0; b_lsu_req = 0; b_lsu_we = 0; b_lsu_mask = 0;
      b_lsu_addr = 0; b_lsu_wdata = 0; b_mdo = 0;
      tick();
      init_mem = 1'b0;

      // Reset with both requesters active on both instances.
      a_if_req = 1'b1; a_if_addr = 8'h10;
      a_store(8'h60, 32'h11112222, 4'hF);
      b_if_req = 1'b1; b_lsu_req = 1'b1;
      chk_reset_zero();
      tick();
      rst = 1'b0; b_if_req = 1'b0; b_lsu_req = 1'b0;
      qa.push_back(g_ev(1'b1, 1'b1, 4'hF, 8'h60, 32'h11112222));
      tick();
      a_lsu_req = 1'b0;
      qa.push_back(g_ev(1'b0, 1'b0, 4'hF, 8'h10, 32'h0));
      qa.push_back(r_ev(1'b0, 32'hDEADBEEF));
      tick();
      a_if_req = 1'b0;
      tick();

      // Store with partial mask, then an immediate IF read of the same word.
      a_store(8'h20, 32'h0000ABCD, 4'b0011);
      qa.push_back(g_ev(1'b1, 1'b1, 4'b0011, 8'h20, 32'h0000ABCD));
      tick();
      a_lsu_req = 1'b0; a_if_req = 1'b1; a_if_addr = 8'h20;
      qa.push_back(g_ev(1'b0, 1'b0, 4'hF, 8'h20, 32'h0));
      qa.push_back(r_ev(1'b0, 32'h1234ABCD));
      tick();
      a_if_req = 1'b0;
      tick();

      // Build up starvation count, then reset while an LSU load is in flight.
      a_if_req = 1'b1; a_if_addr = 8'h10;
      a_store(8'h70, 32'h00007070, 4'hF);
      qa.push_back(g_ev(1'b1, 1'b1, 4'hF, 8'h70, 32'h00007070));
      tick();
      a_lsu_we = 1'b0; a_lsu_addr = 8'h71;
      qa.push_back(g_ev(1'b1, 1'b0, 4'hF, 8'h71, 32'h0));
      tick();
      rst = 1'b1;
      chk_reset_zero();
      tick();
      rst = 1'b0;

      // Starvation: the LSU wins four ties, then IF is forced through.
      for (int k = 0; k < 4; k++) begin
         a_extra_valid = (k == 0);
         a_store(8'h30 + 8'(k), 32'h100 + 32'(k), 4'hF);
         qa.push_back(g_ev(1'b1, 1'b1, 4'hF, 8'h30 + 8'(k), 32'h100 + 32'(k)));
         tick();
      end
      a_extra_valid = 1'b0;
      a_store(8'h34, 32'h104, 4'hF);
      qa.push_back(g_ev(1'b0, 1'b0, 4'hF, 8'h10, 32'h0));
      qa.push_back(r_ev(1'b0, 32'hDEADBEEF));
      qa.push_back(g_ev(1'b1, 1'b1, 4'hF, 8'h34, 32'h104));
      tick();
      a_if_req = 1'b0;
      tick();
      tick();
      a_lsu_req = 1'b0;
      tick();

      // Round-robin instance: continuous reads from both sides alternate.
      b_lsu_we = 1'b0; b_lsu_mask = 4'hF;
      for (int k = 0; k < 3; k++) begin
         b_if_req = 1'b1; b_lsu_req = 1'b1;
         b_if_addr = 8'h40 + 8'(k); b_lsu_addr = 8'h50 + 8'(k);
         qb.push_back(g_ev(1'b1, 1'b0, 4'hF, 8'h50 + 8'(k), 32'h0));
         qb.push_back(r_ev(1'b1, data_pat(8'h50 + 8'(k))));
         tick();
         b_lsu_addr = 8'h51 + 8'(k);
         tick();
         qb.push_back(g_ev(1'b0, 1'b0, 4'hF, 8'h40 + 8'(k), 32'h0));
         qb.push_back(r_ev(1'b0, data_pat(8'h40 + 8'(k))));
         tick();
         b_if_addr = 8'h41 + 8'(k);
         tick();
      end
      b_if_req = 1'b0; b_lsu_req = 1'b0;
      repeat (4) tick();

      total++;
      if (qa.size() != 0 || qb.size() != 0) begin
         bad++;
         $display("FAIL pending_events: got qa=%0d qb=%0d left want 0", qa.size(), qb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
